// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state
// encoding, frame-config field positions and default parameter values.
package uart_pkg;

    localparam int NREQ_DEF         = 4;
    localparam int DATA_W_DEF       = 8;
    localparam int CFG_W_DEF        = 5;
    localparam int BUSY_TIMEOUT_DEF = 64;

    // Frame config layout: {stop, parity_disabled, parity_type, data_bits[1:0]}
    localparam int CFG_DBITS_LSB    = 0;
    localparam int CFG_DBITS_W      = 2;
    localparam int CFG_PAR_TYPE_BIT = 2;
    localparam int CFG_PAR_DIS_BIT  = 3;
    localparam int CFG_STOP_BIT     = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: searches upward from the index after
// 'last', wrapping at NREQ-1, and returns the first requester found.
module rr_picker
    import uart_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int cand;
        logic [IDX_W-1:0] idx;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = 0;
        idx          = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            idx = IDX_W'(cand);
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters with round-robin
// arbitration, a start pulse per frame and a busy-rise timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = NREQ_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CFG_W        = CFG_W_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    parameter int ID_W         = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    input  logic [NREQ*CFG_W-1:0]   req_cfg,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    output logic [CFG_W-1:0]        tx_cfg,
    input  logic                    tx_busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    grant_active,
    output logic                    timeout_err,
    output arb_state_e              state_dbg
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  last_grant;
    logic [NREQ-1:0]  pick_onehot;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             accept;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (ID_W)
    ) u_picker (
        .req          (req_valid),
        .last         (last_grant),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .any          (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter is zero on the first WAIT_BUSY cycle and clears on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_WAIT_BUSY && state_nxt == ST_WAIT_BUSY) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Handshake: requester i transfers in the cycle where req_valid[i] and
    // req_ready[i] are both high; ready is one-hot and only ever raised in
    // IDLE while the UART is not busy, so a requester may hold or drop valid
    // freely at any other time without affecting the frame in flight.
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        req_ready    = '0;
        tx_start     = 1'b0;
        grant_active = 1'b0;
        timeout_err  = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_any && !tx_busy) begin
                        accept    = 1'b1;
                        req_ready = pick_onehot;
                        state_nxt = ST_START;
                    end
                end
                ST_START: begin
                    tx_start     = 1'b1;
                    grant_active = 1'b1;
                    state_nxt    = ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    grant_active = 1'b1;
                    if (tx_busy) begin
                        state_nxt = ST_WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err = 1'b1;
                        state_nxt   = ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    grant_active = 1'b1;
                    if (!tx_busy) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Frame contents are captured once at accept and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data    <= '0;
            tx_cfg     <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(NREQ - 1);
        end else if (accept) begin
            tx_data    <= req_data[pick_idx*DATA_W +: DATA_W];
            tx_cfg     <= req_cfg[pick_idx*CFG_W +: CFG_W];
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART busy model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int CFG_W  = 5;
    localparam int ID_W   = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ*CFG_W-1:0]  req_cfg = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   tx_start;
    logic [DATA_W-1:0]      tx_data;
    logic [CFG_W-1:0]       tx_cfg;
    logic                   tx_busy;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_active;
    logic                   timeout_err;
    arb_state_e             state_dbg;

    logic model_en   = 1'b1;
    logic busy_force = 1'b0;
    logic model_busy;
    int   model_cnt;
    int   busy_len = 3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ID_W-1:0] exp_q[$];

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .DATA_W       (DATA_W),
        .CFG_W        (CFG_W),
        .BUSY_TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_cfg      (req_cfg),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_cfg       (tx_cfg),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .timeout_err  (timeout_err),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // UART model: busy rises the cycle after tx_start and lasts busy_len cycles.
    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (tx_start && model_en) begin
            model_busy <= 1'b1;
            model_cnt  <= busy_len;
        end else if (model_cnt > 1) begin
            model_cnt <= model_cnt - 1;
        end else begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end
    end

    assign tx_busy = model_busy | busy_force;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int i, input logic [DATA_W-1:0] d, input logic [CFG_W-1:0] c);
        req_data[i*DATA_W +: DATA_W] = d;
        req_cfg[i*CFG_W +: CFG_W]    = c;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (grant_active === 1'b1 && k < 300) begin
            tick();
            settle();
            k++;
        end
        check(tag, 32'(grant_active), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_cfg"}, 32'(tx_cfg), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_grant_active"}, 32'(grant_active), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    initial begin
        int starts;
        int accepts;
        int cyc;

        // Reset: outputs zero even with every requester valid
        rst = 1'b1;
        req_valid = 4'b1111;
        tick();
        tick();
        settle();
        check_all_zero("reset");

        // Single request from requester 0
        rst = 1'b0;
        req_valid = 4'b0000;
        busy_len = 3;
        set_req(0, 8'hA5, 5'b00011);
        tick();
        req_valid = 4'b0001;
        settle();
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        settle();
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_gid", 32'(grant_id), 32'd0);
        check("single_ready_off", 32'(req_ready), 32'd0);
        tick();
        settle();
        check("single_start_pulse", 32'(tx_start), 32'd0);
        wait_idle("single_idle");

        // Contention: all valid, 20-cycle busy, grants 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_len = 20;
        for (int i = 0; i < NREQ; i++) set_req(i, DATA_W'(8'h10 + i), CFG_W'(i));
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_valid = 4'b1111;
        settle();
        starts = 0;
        accepts = 0;
        cyc = 0;
        while (starts < 5 && cyc < 400) begin
            if (req_ready != '0) begin
                accepts++;
                check("cont_ready", 32'(req_ready), 32'(4'b0001 << exp_q[0]));
            end
            if (tx_start) begin
                starts++;
                check("cont_gid", 32'(grant_id), 32'(exp_q.pop_front()));
                check("cont_data", 32'(tx_data), 32'h10 + 32'(grant_id));
            end
            tick();
            settle();
            cyc++;
        end
        check("cont_starts", 32'(starts), 32'd5);
        check("cont_accepts", 32'(accepts), 32'd5);
        req_valid = 4'b0000;
        wait_idle("cont_idle");

        // Timeout: UART never raises busy
        model_en = 1'b0;
        set_req(2, 8'h5A, 5'b10100);
        req_valid = 4'b0100;
        settle();
        check("to_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        settle();
        check("to_start", 32'(tx_start), 32'd1);
        for (int k = 1; k <= 64; k++) begin
            tick();
            settle();
            check($sformatf("to_err_c%0d", k), 32'(timeout_err), 32'(k == 64));
        end
        tick();
        settle();
        check("to_back_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("to_err_gone", 32'(timeout_err), 32'd0);
        model_en = 1'b1;
        busy_len = 3;
        req_valid = 4'b0001;
        settle();
        check("to_next_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        settle();
        check("to_next_gid", 32'(grant_id), 32'd0);
        wait_idle("to_next_idle");

        // Busy held externally blocks the grant
        busy_force = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("busy_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        busy_force = 1'b0;
        settle();
        check("busy_release_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        settle();
        check("busy_release_start", 32'(tx_start), 32'd1);
        check("busy_release_gid", 32'(grant_id), 32'd1);
        wait_idle("busy_idle");

        // Config pass-through from requester 2, held while inputs change
        set_req(2, 8'h3C, 5'b00111);
        req_valid = 4'b0100;
        settle();
        check("cfg_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        set_req(2, 8'hFF, 5'b11000);
        settle();
        check("cfg_gid", 32'(grant_id), 32'd2);
        for (int k = 0; k < 8; k++) begin
            check("cfg_hold", 32'(tx_cfg), 32'b00111);
            tick();
            settle();
        end
        wait_idle("cfg_idle");
        check("cfg_hold_idle", 32'(tx_cfg), 32'b00111);
        check("data_hold_idle", 32'(tx_data), 32'h3C);
        set_req(0, 8'h81, 5'b10001);
        req_valid = 4'b0001;
        settle();
        check("cfg_next_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        settle();
        check("cfg_next_cfg", 32'(tx_cfg), 32'b10001);
        check("cfg_next_data", 32'(tx_data), 32'h81);
        wait_idle("cfg_next_idle");

        // Reset during WAIT_DONE aborts the frame; requester 0 wins next
        busy_len = 20;
        set_req(3, 8'hC3, 5'b01010);
        req_valid = 4'b1000;
        settle();
        check("rst_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        settle();
        check("rst_in_wait_done", 32'(state_dbg), 32'(ST_WAIT_DONE));
        check("rst_gid", 32'(grant_id), 32'd3);
        rst = 1'b1;
        settle();
        check("rst_no_timeout", 32'(timeout_err), 32'd0);
        check("rst_active_low", 32'(grant_active), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check_all_zero("rst_after");
        req_valid = 4'b1111;
        settle();
        check("rst_next_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        settle();
        check("rst_next_gid", 32'(grant_id), 32'd0);
        check("rst_next_start", 32'(tx_start), 32'd1);
        wait_idle("rst_next_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
